// File: rtl/fifo_drain.sv
// fifo_drain: drains COUNT words from a FIFO read port into a valid/ready stream.
// Optional FIFO_DRAIN_STATS_EN adds stat_words, a running count of stream transfers.
module fifo_drain #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_dataout,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]      stat_words
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rem_q;
  logic             inflight_q;
  logic [1:0]       occ_q;
  logic [WIDTH-1:0] b0_q;
  logic [WIDTH-1:0] b1_q;

  logic             pop;
  logic             cap;
  logic             rem_nz;
  logic             last_rd;
  logic [2:0]       pend;

  assign pop     = m_valid & m_ready;
  assign cap     = inflight_q;
  assign rem_nz  = (rem_q != '0);
  assign last_rd = (rem_q == CNT_W'(1));
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = b0_q;

  // Words that will still be held after this cycle's pop; the read
  // is only issued while a free slot is guaranteed for its data.
  assign pend = {1'b0, occ_q}
              + {2'b00, inflight_q}
              - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    fifo_read = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) state_d = S_DONE;
          else             state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        fifo_read = ~fifo_empty & rem_nz
                  & (pend < 3'd2);
        if (fifo_read && last_rd)
          state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (occ_q == 2'd0 && !inflight_q)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_read;
      if (state_q == S_IDLE && start)
        rem_q <= count;
      else if (fifo_read)
        rem_q <= rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= 2'd0;
      b0_q  <= '0;
      b1_q  <= '0;
    end else begin
      unique case ({cap, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            b0_q <= b1_q;
            b1_q <= fifo_dataout;
          end else begin
            b0_q <= fifo_dataout;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) b0_q <= fifo_dataout;
          else               b1_q <= fifo_dataout;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          b0_q  <= b1_q;
          occ_q <= occ_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   stat_words <= '0;
    else if (pop) stat_words <= stat_words + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed + random bursts against a queue-based FIFO and
// an in-order expected-word scoreboard.
module tb_fifo_drain;
  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          m_ready = 1'b0;
  logic          hold_empty = 1'b0;
  logic [W-1:0]  fifo_dataout = '0;
  logic          fifo_empty;
  logic          busy, done, fifo_read, m_valid;
  logic [W-1:0]  m_data;
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0]   stat_words;
`endif

  logic [W-1:0] fq[$];
  logic [W-1:0] exq[$];
  int fsize = 0;
  int cyc = 0, t0 = 0;
  int n_cmp = 0, n_bad = 0;
  int reads = 0, xfers = 0, dones = 0;
  int r0 = 0, x0 = 0, d0 = 0;
  int first_x = -1, last_x = -1, done_at = -1;
  int stat_exp = 0;
  bit rd_seen = 0, hold_prev = 0, busy_seen = 0;
  logic [W-1:0] data_prev = '0;

  assign fifo_empty = (fsize == 0) | hold_empty;

  always #5 clk = ~clk;

  fifo_drain #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .count(count),
    .busy(busy),
    .done(done),
    .fifo_read(fifo_read),
    .fifo_dataout(fifo_dataout),
    .fifo_empty(fifo_empty),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .stat_words(stat_words)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  // FIFO model: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rd_seen) begin
      if (fq.size() != 0) fifo_dataout = fq.pop_front();
      rd_seen = 0;
    end
    fsize = fq.size();
  end

  always @(negedge clk) begin
    if (fifo_read) begin
      chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      reads++;
      rd_seen = 1;
    end
    if (busy) busy_seen = 1;
    if (m_valid && m_ready) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      if (exq.size() == 0)
        chk("xfer_extra", 32'd1, 32'd0);
      else
        chk("data", m_data, exq.pop_front());
      xfers++;
      stat_exp++;
    end
    if (fifo_read)
      chk("outstanding_le2", {31'd0, (reads - xfers) <= 2}, 32'd1);
    if (hold_prev && rst_n) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", m_data, data_prev);
    end
    hold_prev = m_valid & ~m_ready & rst_n;
    data_prev = m_data;
    if (done) begin
      dones++;
      done_at = cyc;
      chk("done_not_busy", {31'd0, busy}, 32'd0);
    end
  end

  task automatic preload(input logic [W-1:0] v);
    fq.push_back(v);
    fsize = fq.size();
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) exq.push_back(fq[i]);
    start = 1'b1;
    count = CW'(n);
    t0 = cyc;
    first_x = -1; last_x = -1; done_at = -1;
    r0 = reads; x0 = xfers; d0 = dones;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int k;
    k = 0;
    while (dones == d0 && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (rnd) begin
        m_ready    = ($urandom_range(0, 3) != 0);
        hold_empty = ($urandom_range(0, 5) == 0);
      end
    end
    hold_empty = 1'b0;
    chk("done_timeout", {31'd0, dones != d0}, 32'd1);
  endtask

  task automatic burst_end(input int n);
    chk("xfers", xfers - x0, n);
    chk("reads", reads - r0, n);
    chk("dones", dones - d0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int k, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_read",  {31'd0, fifo_read}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data",  m_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 1: three words, free-flowing
    preload(32'd1); preload(32'd2); preload(32'd3);
    m_ready = 1'b1;
    go(3);
    wait_done(0);
    burst_end(3);
    chk("t1_first_x", first_x - t0, 3);
    chk("t1_last_x", last_x - t0, 5);
    chk("t1_done_at", done_at - t0, 7);
    chk("t1_fsize", fsize, 0);
    idle(2);

    // 2: zero count
    preload(32'hAA);
    busy_seen = 0;
    go(0);
    wait_done(0);
    burst_end(0);
    chk("t2_done_at", done_at - t0, 1);
    chk("t2_busy_seen", {31'd0, busy_seen}, 32'd0);
    chk("t2_fsize", fsize, 1);
    idle(2);

    // 3: backpressure
    for (int i = 0; i < 4; i++) preload(32'h300 + i);
    m_ready = 1'b0;
    go(4);
    idle(10);
    chk("t3_reads_bp", reads - r0, 2);
    @(negedge clk);
    chk("t3_valid", {31'd0, m_valid}, 32'd1);
    chk("t3_head", m_data, 32'hAA);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(0);
    burst_end(4);
    idle(2);

    // 4: fifo_empty pause
    for (int i = 0; i < 5; i++) preload(32'h400 + i);
    go(5);
    k = 0;
    while ((reads - r0) < 2 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    hold_empty = 1'b1;
    idle(6);
    chk("t4_reads_pause", reads - r0, 2);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    hold_empty = 1'b0;
    wait_done(0);
    burst_end(5);
    chk("t4_fsize", fsize, 1);
    idle(2);

    // 5: reset mid-burst with two words buffered
    for (int i = 0; i < 4; i++) preload(32'h500 + i);
    m_ready = 1'b0;
    go(4);
    idle(6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    idle(2);
    chk("t5_no_done", dones - d0, 0);
    fq.delete(); exq.delete();
    fsize = 0; reads = 0; xfers = 0; stat_exp = 0;
    rst_n = 1'b1;
    idle(1);
    preload(32'h55);
    m_ready = 1'b1;
    go(1);
    wait_done(0);
    burst_end(1);
    idle(2);
`ifdef FIFO_DRAIN_STATS_EN
    chk("t5_stat", stat_words, stat_exp);
`endif

    // 6: start while busy is ignored
    for (int i = 0; i < 6; i++) preload(32'h600 + i);
    go(6);
    idle(1);
    start = 1'b1; count = CW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);
    burst_end(6);
    chk("t6_fsize", fsize, 0);
    idle(3);
    chk("t6_no_redo", dones - d0, 1);

    // random bursts
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(0, 10);
      k = $urandom_range(0, 2);
      for (int i = 0; i < n + k; i++) preload($urandom);
      go(n);
      wait_done(1);
      burst_end(n);
      m_ready = 1'b1;
      idle(1);
    end
    idle(3);
    chk("exq_empty", exq.size(), 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("stat_final", stat_words, stat_exp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
